// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Multiplexed hex seven-segment scanner with per-frame snapshot,
//             leading-zero blanking, decimal points and PWM brightness.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                  Clk_100M,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     DecimalPoints,
    input  logic                  BlankLeadingZeros,
    input  logic [PWM_BITS:0]     Brightness,
    input  logic                  Enable,
    output logic [DIGITS-1:0]     SegmentDrivers,
    output logic [7:0]            SevenSegment,
    output logic                  FrameStart
);

    localparam int unsigned TICKS_RAW = CLK_HZ / SCAN_HZ;
    localparam int unsigned TICKS     = (TICKS_RAW < 2) ? 2 : TICKS_RAW;
    localparam int unsigned SLOT_W    = $clog2(TICKS);
    localparam int unsigned DIGIT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(TICKS - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);

    // Active-low gfedcba patterns for hex digits 0..F.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [SLOT_W-1:0]   slot_cnt_q,  slot_cnt_d;
    logic [DIGIT_W-1:0]  digit_idx_q, digit_idx_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;

    logic [4*DIGITS-1:0] snap_value_q, snap_value_d;
    logic [DIGITS-1:0]   snap_dp_q,    snap_dp_d;
    logic                snap_blz_q,   snap_blz_d;

    logic [DIGITS-1:0]   seg_drv_q,     seg_drv_d;
    logic [7:0]          seven_seg_q,   seven_seg_d;
    logic                frame_start_q, frame_start_d;

    logic                snap_cycle;
    logic                slot_wrap;
    logic [DIGITS-1:0]   zero_above;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                drive_ok;

    always_comb begin
        snap_cycle  = (slot_cnt_q == '0) && (digit_idx_q == '0);
        slot_wrap   = (slot_cnt_q == SLOT_LAST);

        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + DIGIT_W'(1);
        end
        pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);

        snap_value_d = snap_value_q;
        snap_dp_d    = snap_dp_q;
        snap_blz_d   = snap_blz_q;
        if (snap_cycle) begin
            snap_value_d = Value;
            snap_dp_d    = DecimalPoints;
            snap_blz_d   = BlankLeadingZeros;
        end
    end

    // The decode works from the snapshot as it will be after this cycle, so the
    // first slot of a frame already shows the freshly captured value.
    always_comb begin
        zero_above = '0;
        zero_above[DIGITS-1] = (snap_value_d[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
            zero_above[i] = zero_above[i+1] && (snap_value_d[4*i +: 4] == 4'h0);
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit_idx_q == DIGIT_W'(i)) begin
                cur_nib   = snap_value_d[4*i +: 4];
                cur_dp    = snap_dp_d[i];
                cur_blank = (i != 0) && snap_blz_d && zero_above[i];
            end
        end

        seven_seg_d = {~cur_dp, cur_blank ? 7'h7F : hex_to_seg(cur_nib)};

        // Slot position 0 is a dead cycle so the previous digit's segments never
        // bleed onto the newly selected anode.
        drive_ok = Enable && (slot_cnt_q != '0) && ({1'b0, pwm_cnt_q} < Brightness);
        seg_drv_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (drive_ok && (digit_idx_q == DIGIT_W'(i))) begin
                seg_drv_d[i] = 1'b0;
            end
        end

        frame_start_d = snap_cycle;
    end

    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            pwm_cnt_q     <= '0;
            snap_value_q  <= '0;
            snap_dp_q     <= '0;
            snap_blz_q    <= 1'b0;
            seg_drv_q     <= '1;
            seven_seg_q   <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            pwm_cnt_q     <= pwm_cnt_d;
            snap_value_q  <= snap_value_d;
            snap_dp_q     <= snap_dp_d;
            snap_blz_q    <= snap_blz_d;
            seg_drv_q     <= seg_drv_d;
            seven_seg_q   <= seven_seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign SegmentDrivers = seg_drv_q;
    assign SevenSegment   = seven_seg_q;
    assign FrameStart     = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver against a cycle-indexed
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int CLK_HZ   = 16;
    localparam int SCAN_HZ  = 2;
    localparam int PWM_BITS = 2;
    localparam int TICKS    = CLK_HZ / SCAN_HZ;
    localparam int FRAME    = TICKS * DIGITS;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Value = '0;
    logic [3:0]  DecimalPoints = '0;
    logic        BlankLeadingZeros = 1'b0;
    logic [2:0]  Brightness = '0;
    logic        Enable = 1'b0;
    logic [3:0]  SegmentDrivers;
    logic [7:0]  SevenSegment;
    logic        FrameStart;

    int errors = 0;
    int checks = 0;
    int t = 0;

    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;
    logic        m_blz = 1'b0;
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver #(
        .DIGITS   (DIGITS),
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .Clk_100M          (clk),
        .Reset             (Reset),
        .Value             (Value),
        .DecimalPoints     (DecimalPoints),
        .BlankLeadingZeros (BlankLeadingZeros),
        .Brightness        (Brightness),
        .Enable            (Enable),
        .SegmentDrivers    (SegmentDrivers),
        .SevenSegment      (SevenSegment),
        .FrameStart        (FrameStart)
    );

    always #5 clk = ~clk;

    // Predicts the outputs produced from scan position t (cycles since reset
    // release), then clocks once and samples 1 ns after the edge.
    task automatic advance(output logic [3:0] e_drv, output logic [7:0] e_seg, output logic e_fs);
        int slot, digit, pwm;
        logic [15:0] upper;
        logic blank;
        if (t % FRAME == 0) begin
            m_val = Value;
            m_dp  = DecimalPoints;
            m_blz = BlankLeadingZeros;
        end
        slot  = t % TICKS;
        digit = (t / TICKS) % DIGITS;
        pwm   = t % (1 << PWM_BITS);
        e_drv = 4'hF;
        if (Enable && slot != 0 && pwm < int'(Brightness)) e_drv[digit] = 1'b0;
        upper = m_val >> (4 * digit);
        blank = (digit > 0) && m_blz && (upper == 16'h0);
        e_seg = {~m_dp[digit], blank ? 7'h7F : hex_tab[m_val[4*digit +: 4]]};
        e_fs  = (t % FRAME == 0);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset();
        Value = 16'h12AF; DecimalPoints = 4'h0; BlankLeadingZeros = 1'b0;
        Brightness = 3'd4; Enable = 1'b1;
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (SegmentDrivers !== 4'hF) begin
            errors++; $display("FAIL reset_drivers got=%h expected=%h", SegmentDrivers, 4'hF);
        end
        checks++;
        if (SevenSegment !== 8'hFF) begin
            errors++; $display("FAIL reset_segments got=%h expected=%h", SevenSegment, 8'hFF);
        end
        checks++;
        if (FrameStart !== 1'b0) begin
            errors++; $display("FAIL reset_framestart got=%b expected=%b", FrameStart, 1'b0);
        end
        @(negedge clk);
        Reset = 1'b0;
        t = 0;
    endtask

    task automatic test_basic_scan();
        logic [3:0] ed; logic [7:0] es; logic ef;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance(ed, es, ef);
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL basic_scan t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
            if (i == 0 || i == 3 || i == 10 || i == 20 || i == 30) begin
                checks++;
                if (SevenSegment !== (i == 0 || i == 3 ? 8'h8E : i == 10 ? 8'h88 : i == 20 ? 8'hA4 : 8'hF9)) begin
                    errors++; $display("FAIL basic_table i=%0d got seg=%h", i, SevenSegment);
                end
            end
            if (i == 0 || i == 3) begin
                checks++;
                if (SegmentDrivers !== (i == 0 ? 4'hF : 4'b1110)) begin
                    errors++; $display("FAIL basic_guard i=%0d got drv=%b", i, SegmentDrivers);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] ed; logic [7:0] es; logic ef;
        Value = 16'h0030; DecimalPoints = 4'b1000; BlankLeadingZeros = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 2 * FRAME) Value = 16'h0000;
            advance(ed, es, ef);
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL blanking t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
            if (i == 1 || i == 9 || i == 17 || i == 25 || i == 65 || i == 73) begin
                checks++;
                if (SevenSegment !== (i == 1 || i == 65 ? 8'hC0 : i == 9 ? 8'hB0 : i == 25 ? 8'h7F : 8'hFF)) begin
                    errors++; $display("FAIL blank_table i=%0d got seg=%h", i, SevenSegment);
                end
            end
        end
        DecimalPoints = 4'h0; BlankLeadingZeros = 1'b0;
    endtask

    task automatic test_brightness();
        logic [3:0] ed; logic [7:0] es; logic ef;
        int active;
        int exp_active [5] = '{0, 4, 12, 20, 28};
        Value = 16'($urandom);
        for (int b = 0; b <= 4; b++) begin
            Brightness = 3'(b);
            active = 0;
            for (int i = 0; i < FRAME; i++) begin
                advance(ed, es, ef);
                if (SegmentDrivers !== 4'hF) active++;
                checks++;
                if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                    errors++;
                    $display("FAIL brightness b=%0d t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                             b, t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
                end
            end
            checks++;
            if (active !== exp_active[b]) begin
                errors++; $display("FAIL bright_count b=%0d got=%0d expected=%0d", b, active, exp_active[b]);
            end
        end
    endtask

    task automatic test_midframe_update();
        logic [3:0] ed; logic [7:0] es; logic ef;
        Value = 16'h1111; Brightness = 3'd4;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 12) Value = 16'h2222;
            advance(ed, es, ef);
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL midframe t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
            if (i == 20 || i == 28 || i == 52) begin
                checks++;
                if (SevenSegment !== (i == 52 ? 8'hA4 : 8'hF9)) begin
                    errors++; $display("FAIL midframe_table i=%0d got seg=%h", i, SevenSegment);
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] ed; logic [7:0] es; logic ef;
        int active;
        active = 0;
        Enable = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == FRAME) Enable = 1'b1;
            advance(ed, es, ef);
            if (i < FRAME && SegmentDrivers !== 4'hF) active++;
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL enable t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
        end
        checks++;
        if (active !== 0) begin
            errors++; $display("FAIL enable_off_count got=%0d expected=0", active);
        end
    endtask

    task automatic test_random();
        logic [3:0] ed; logic [7:0] es; logic ef;
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (i % FRAME == 0) begin
                DecimalPoints     = 4'($urandom);
                BlankLeadingZeros = 1'($urandom);
            end
            if ($urandom_range(0, 7) == 0)
                Value = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            Brightness = 3'($urandom_range(0, 7));
            Enable     = ($urandom_range(0, 7) != 0);
            advance(ed, es, ef);
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL random t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [3:0] ed; logic [7:0] es; logic ef;
        Value = 16'h12AF; DecimalPoints = 4'h0; BlankLeadingZeros = 1'b0;
        Brightness = 3'd4; Enable = 1'b1;
        for (int i = 0; i < FRAME && (t % FRAME) != 2 * TICKS + 5; i++) begin
            advance(ed, es, ef);
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL pre_reset t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({SegmentDrivers, SevenSegment, FrameStart} !== {4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got drv=%b seg=%h fs=%b expected drv=1111 seg=ff fs=0",
                     SegmentDrivers, SevenSegment, FrameStart);
        end
        Value = 16'h5678;
        @(negedge clk);
        Reset = 1'b0;
        t = 0;
        for (int i = 0; i < FRAME; i++) begin
            advance(ed, es, ef);
            checks++;
            if ({SegmentDrivers, SevenSegment, FrameStart} !== {ed, es, ef}) begin
                errors++;
                $display("FAIL post_reset t=%0d got drv=%b seg=%h fs=%b expected drv=%b seg=%h fs=%b",
                         t - 1, SegmentDrivers, SevenSegment, FrameStart, ed, es, ef);
            end
            if (i == 0) begin
                checks++;
                if ({SegmentDrivers, SevenSegment, FrameStart} !== {4'hF, 8'h80, 1'b1}) begin
                    errors++;
                    $display("FAIL post_reset_first got drv=%b seg=%h fs=%b expected drv=1111 seg=80 fs=1",
                             SegmentDrivers, SevenSegment, FrameStart);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_blanking();
        test_brightness();
        test_midframe_update();
        test_enable();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
